sync_fifo_param: RTL
====================

# sync_fifo_param

Parametrised synchronous FIFO for single-clock datapaths, replacing fixed 8x16 instances in the design. It adds configurable width and depth, a true DEPTH-entry full condition, and correct simultaneous read/write. It also provides occupancy output, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.

## Interface
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=4
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write request
- data_in  in  WIDTH  write data
- rd_en  in  1  read request (pop)
- err_clr  in  1  clears overflow/underflow sticky flags
- data_out  out  WIDTH  read data
- rd_valid  out  1  standard mode: data_out updated this cycle; FWFT mode: equals ~empty
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Pointers wr_ptr, rd_ptr are $clog2(DEPTH) bits, wrap naturally from DEPTH-1 to 0; occupancy held in count register (one extra bit).
- Write accepted (wr_acc) = wr_en & ~full: mem[wr_ptr] <= data_in, wr_ptr increments.
- Read accepted (rd_acc) = rd_en & ~empty: rd_ptr increments.
- Count update: wr_acc & ~rd_acc -> +1; rd_acc & ~wr_acc -> -1; both or neither -> unchanged.
- Full with wr_en & rd_en: read accepted, write rejected (overflow sets); count becomes DEPTH-1.
- Empty with wr_en & rd_en: write accepted, read rejected (underflow sets); count becomes 1. No bypass of write data to output.
- Flags full/empty/almost_* are combinational decodes of the count register only.
- overflow sets on wr_en & full; underflow sets on rd_en & empty. Both hold until err_clr or rst. A set and err_clr in the same cycle: set wins.
- Standard mode (FWFT=0): on rd_acc, data_out <= mem[rd_ptr] and rd_valid pulses high for the following cycle. Otherwise data_out holds and rd_valid is 0.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] when ~empty, else 0. rd_en acknowledges the displayed word; rd_valid = ~empty.
- Memory contents are not reset; reads of unwritten locations are impossible by construction.
- Reset: pointers, count, overflow, underflow, data_out, rd_valid all reset to 0. Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0 (for AF_LEVEL>=1). rst overrides all other inputs, including mid-burst; any queued data is discarded.

## Timing
- Write at edge N: count, full, almost_full, and (FWFT) data_out/empty reflect it after edge N. First-word latency is 1 cycle in FWFT mode.
- Standard read: rd_en sampled at edge N; data_out/rd_valid valid after edge N (1-cycle latency). Back-to-back reads give one word per cycle.
- Sustained simultaneous read+write at 0<count<DEPTH: full throughput, count constant.
- Error flags are visible the cycle after the offending request.

## Test plan
- Reset, then write 0x01..0x10 (DEPTH=16, WIDTH=8) -> full=1, count=16 after 16th write. 17th write 0xAA is rejected and overflow=1. Reads return 0x01..0x10 in order, then empty=1.
- Wrap-around: write 10, read 10, write 10, read 10 -> data order preserved, count returns to 0.
- Full + wr_en + rd_en -> count=15, oldest word returned, overflow=1. Empty + wr_en + rd_en -> count=1, underflow=1, rd_valid=0.
- Flags with AF_LEVEL=14, AE_LEVEL=2 -> almost_empty high at count 0..2 and low at 3. almost_full low at 13 and high at 14..16.
- FWFT=1: single write 0x5A -> next cycle empty=0, data_out=0x5A with rd_en low. rd_en -> empty=1, data_out=0.
- rst asserted at count=7 mid-stream -> next cycle count=0, empty=1, data_out=0, errors cleared. Then err_clr with overflow set -> overflow=0.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The master drives the requests; the slave (the FIFO) drives the data and status.
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             i_wr_en;
  logic [WIDTH-1:0] i_data_in;
  logic             i_rd_en;
  logic             i_err_clr;

  logic [WIDTH-1:0] o_data_out;
  logic             o_rd_valid;
  logic             o_full;
  logic             o_empty;
  logic             o_almost_full;
  logic             o_almost_empty;
  logic [CW-1:0]    o_count;
  logic             o_overflow;
  logic             o_underflow;

  modport master (
    output i_wr_en, i_data_in, i_rd_en, i_err_clr,
    input  o_data_out, o_rd_valid, o_full, o_empty, o_almost_full,
           o_almost_empty, o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_wr_en, i_data_in, i_rd_en, i_err_clr,
    output o_data_out, o_rd_valid, o_full, o_empty, o_almost_full,
           o_almost_empty, o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, almost flags, sticky errors
// and a selectable registered or first-word-fall-through read port.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave io_fifo
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Status flags decode the count register only, so they never see input glitches.
  always_comb begin
    w_full   = (r_count == C_DEPTH);
    w_empty  = (r_count == '0);
    w_wr_acc = io_fifo.i_wr_en & ~w_full;
    w_rd_acc = io_fifo.i_rd_en & ~w_empty;
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= io_fifo.i_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (io_fifo.i_wr_en & w_full)  | (r_overflow  & ~io_fifo.i_err_clr);
      r_underflow <= (io_fifo.i_rd_en & w_empty) | (r_underflow & ~io_fifo.i_err_clr);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign io_fifo.o_data_out = w_empty ? '0 : r_mem[r_rd_ptr];
      assign io_fifo.o_rd_valid = ~w_empty;
    end else begin : g_std
      logic [WIDTH-1:0] r_data_out;
      logic             r_rd_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_data_out <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) begin
            r_data_out <= r_mem[r_rd_ptr];
          end
        end
      end

      assign io_fifo.o_data_out = r_data_out;
      assign io_fifo.o_rd_valid = r_rd_valid;
    end
  endgenerate

  assign io_fifo.o_full         = w_full;
  assign io_fifo.o_empty        = w_empty;
  assign io_fifo.o_almost_full  = (r_count >= C_AF);
  assign io_fifo.o_almost_empty = (r_count <= C_AE);
  assign io_fifo.o_count        = r_count;
  assign io_fifo.o_overflow     = r_overflow;
  assign io_fifo.o_underflow    = r_underflow;
endmodule
